// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_t  : per-slot scan state (BLANK = anodes off, SHOW = one anode on)
//   DEF_*         : default timing/size parameters
//   cnt_width()   : counter width helper, $clog2 with a floor of 1 bit
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_PRESCALE     = 50000;
    localparam int DEF_BLANK_CYCLES = 16;

    function automatic int cnt_width(input int range_len);
        return (range_len > 1) ? $clog2(range_len) : 1;
    endfunction

endpackage

// File: rtl/seg7_digit_buffer.sv
// seg7_digit_buffer: double buffer for the displayed digits.
//   clk, rst   : clock, synchronous active-high reset
//   load       : producer request, digits_in captured into the pending buffer
//   digits_in  : BCD digits, digit k at [4k+3:4k]
//   boundary   : last cycle of the frame; the only cycle disp may change
//   load_ack   : one-cycle pulse after a commit (pending or bypass)
//   disp       : digits currently on display
//   lz_mask    : per-digit leading-zero blank mask, registered with disp
// Optional: SEG7_LEADING_ZERO_BLANK_EN enables the leading-zero mask;
// without it lz_mask is constant zero.
module seg7_digit_buffer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     digits_in,
    input  logic                        boundary,
    output logic                        load_ack,
    output logic [NUM_DIGITS-1:0][3:0]  disp,
    output logic [NUM_DIGITS-1:0]       lz_mask
);

    logic [NUM_DIGITS-1:0][3:0] din;
    logic [NUM_DIGITS-1:0][3:0] pend;
    logic                       pending;

    assign din = digits_in;

    // A load in the boundary cycle wins over an older pending value, so the
    // producer's latest request is always the one that lands in disp.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp     <= '0;
            pend     <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (boundary && load) begin
                disp     <= din;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (boundary && pending) begin
                disp     <= pend;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (load) begin
                pend    <= din;
                pending <= 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit k>0 is blanked when it and every more-significant digit is zero.
    function automatic logic [NUM_DIGITS-1:0] lz_of(input logic [NUM_DIGITS-1:0][3:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (d[k] == 4'd0);
            m[k]       = zero_above;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            lz_mask <= '0;
        end else if (boundary && load) begin
            lz_mask <= lz_of(din);
        end else if (boundary && pending) begin
            lz_mask <= lz_of(pend);
        end
    end
`else
    assign lz_mask = '0;
`endif

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display sharing one BCD decoder.
//   clk, rst    : clock, synchronous active-high reset
//   load        : request to display digits_in (any cycle)
//   digits_in   : BCD digits, digit 0 least significant at [3:0]
//   load_ack    : one-cycle pulse when a load reaches the display buffer
//   bcd_out     : BCD code of the digit in the current slot
//   an          : active-low anode enables, at most one low
//   frame_tick  : one-cycle pulse after the last slot of a frame
// Optional: SEG7_LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [4*NUM_DIGITS-1:0]  digits_in,
    output logic                     load_ack,
    output logic [3:0]               bcd_out,
    output logic [NUM_DIGITS-1:0]    an,
    output logic                     frame_tick
);

    localparam int CW = cnt_width(PRESCALE);
    localparam int IW = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;
    scan_state_t                state;
    logic                       slot_end;
    logic                       boundary;
    logic [NUM_DIGITS-1:0]      sel;
    logic [NUM_DIGITS-1:0]      lz_mask;
    logic [NUM_DIGITS-1:0][3:0] disp;

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);
    assign sel      = NUM_DIGITS'(1) << idx;

    seg7_digit_buffer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .boundary  (boundary),
        .load_ack  (load_ack),
        .disp      (disp),
        .lz_mask   (lz_mask)
    );

    // state tracks the slot position of cnt (SHOW iff cnt >= BLANK_CYCLES);
    // outputs are registered from state/idx, so they trail cnt by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= BLANK;
            an         <= '1;
            bcd_out    <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            case (state)
                BLANK: if (cnt == BLANK_LAST) state <= SHOW;
                SHOW:  if (slot_end)          state <= BLANK;
                default:                      state <= BLANK;
            endcase

            // A masked digit leaves its own anode bit high as well.
            an         <= (state == SHOW) ? (~sel | (sel & lz_mask)) : '1;
            bcd_out    <= disp[idx];
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
// cyc counts cycles since the last reset edge; cycle 0 is the reset state.
// Stimulus pushes the expected SHOW slots and load_ack cycles; the monitor
// pops an entry each time an anode goes low or load_ack pulses.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic        load_ack;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        frame_tick;

    slot_t slot_q[$];
    int    ack_q[$];
    int    cyc;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ticks    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits_in  (digits_in),
        .load_ack   (load_ack),
        .bcd_out    (bcd_out),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_slot(input logic [3:0] a, input logic [3:0] b);
        slot_t s;
        s.an  = a;
        s.bcd = b;
        slot_q.push_back(s);
    endtask

    task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        push_slot(4'b1110, d0);
        push_slot(4'b1101, d1);
        push_slot(4'b1011, d2);
        push_slot(4'b0111, d3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        for (int i = 0; i < 1000 && cyc < t; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d);
        load      = 1'b1;
        digits_in = d;
        step();
        load      = 1'b0;
    endtask

    // Monitor
    initial begin
        logic [3:0] prev_an;
        logic [3:0] run_an;
        int         run_len;
        int         exp_ack;
        slot_t      e;
        prev_an = 4'hF;
        run_an  = 4'hF;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_an = 4'hF;
                run_len = 0;
            end else begin
                if (an != 4'hF) begin
                    if (prev_an == 4'hF) begin
                        if (slot_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL slot_extra at cyc %0d: got an=%b bcd=%0h, expected no slot", cyc, an, bcd_out);
                        end else begin
                            e = slot_q.pop_front();
                            check("slot_an", 32'(an), 32'(e.an));
                            check("slot_bcd", 32'(bcd_out), 32'(e.bcd));
                        end
                        run_an  = an;
                        run_len = 1;
                    end else begin
                        run_len++;
                        check("an_hold", 32'(an), 32'(run_an));
                    end
                end else if (prev_an != 4'hF) begin
                    check("show_len", 32'(run_len), 32'd6);
                end

                if (load_ack) begin
                    if (ack_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ack_unexpected at cyc %0d: got load_ack=1, expected 0", cyc);
                    end else begin
                        exp_ack = ack_q.pop_front();
                        check("ack_cycle", 32'(cyc), 32'(exp_ack));
                    end
                end

                if (frame_tick) begin
                    ticks++;
                    check("tick_cycle", 32'((cyc % 32 == 0) && (cyc != 0)), 32'd1);
                end
                prev_an = an;
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_an", 32'(an), 32'hF);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_ack", 32'(load_ack), 32'h0);
        check("rst_tick", 32'(frame_tick), 32'h0);
        check("rst_cnt", 32'(dut.cnt), 32'h0);

        // Frame 0: empty display
        push_frame(4'd0, 4'd0, 4'd0, 4'd0);

        // Mid-frame load commits at the boundary
        wait_to(5);
        do_load(16'h4321);
        push_frame(4'd1, 4'd2, 4'd3, 4'd4);
        ack_q.push_back(32);

        // Two loads in one frame: latest wins, one ack
        wait_to(40);
        do_load(16'h1111);
        wait_to(50);
        do_load(16'h2222);
        push_frame(4'd2, 4'd2, 4'd2, 4'd2);
        ack_q.push_back(64);

        // Load in the boundary cycle (cnt=7, idx=3) bypasses into disp
        wait_to(95);
        check("bnd_cnt", 32'(dut.cnt), 32'd7);
        check("bnd_idx", 32'(dut.idx), 32'd3);
        do_load(16'h9876);
        push_slot(4'b1110, 4'd6);
        push_slot(4'b1101, 4'd7);
        push_slot(4'b1011, 4'd8);
        ack_q.push_back(96);

        // Pending load then reset during SHOW of digit 2
        wait_to(100);
        do_load(16'h1234);
        wait_to(116);
        check("pre_rst_an", 32'(an), 32'hB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_cnt", 32'(dut.cnt), 32'h0);
        check("mid_rst_idx", 32'(dut.idx), 32'h0);
        check("mid_rst_ack", 32'(load_ack), 32'h0);
        check("mid_rst_bcd", 32'(bcd_out), 32'h0);

        // Pending load discarded: two frames of zeros, no ack at 32
        push_frame(4'd0, 4'd0, 4'd0, 4'd0);
        push_frame(4'd0, 4'd0, 4'd0, 4'd0);

        // Leading-zero value
        wait_to(40);
        do_load(16'h0050);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        push_slot(4'b1110, 4'd0);
        push_slot(4'b1101, 4'd5);
`else
        push_frame(4'd0, 4'd5, 4'd0, 4'd0);
`endif
        ack_q.push_back(64);
        push_slot(4'b1110, 4'd0);

        wait_to(100);
        check("slots_left", 32'(slot_q.size()), 32'd0);
        check("acks_left", 32'(ack_q.size()), 32'd0);
        check("tick_count", 32'(ticks), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It owns one shared BCD-to-seven-segment decoder: each scan slot it presents one digit's BCD code on bcd_out and enables that digit's anode. Digit updates arrive through a load/ack handshake and are double-buffered, so the display never changes mid-frame. It sits between the number-producing logic and the existing combinational decoder plus display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 50000, clk cycles per digit slot (>= 4)
BLANK_CYCLES, 16, anode-off cycles at the start of each slot for ghosting suppression (1..PRESCALE-2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
load  input  1  request to display digits_in
digits_in  input  4*NUM_DIGITS  BCD digits; digit k = digits_in[4k+3:4k]; digit 0 is least significant
load_ack  output  1  one-cycle pulse when a load is committed to the display buffer
bcd_out  output  4  BCD code of the current digit, fed to the shared decoder
an  output  NUM_DIGITS  active-low anode enables; at most one bit low
frame_tick  output  1  one-cycle pulse at the end of the last digit slot

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - an = all ones; bcd_out = 0; load_ack = 0; frame_tick = 0.
  - Slot counter cnt = 0; digit index idx = 0; state = BLANK.
  - Display buffer and pending buffer = 0; pending flag = 0.
  - Reset mid-frame aborts the slot immediately and discards any pending load.
- Slot counter: cnt runs 0..PRESCALE-1 and wraps. On wrap, idx advances by 1, and NUM_DIGITS-1 wraps to 0.
- FSM per slot:
  - BLANK while cnt < BLANK_CYCLES: an all ones, bcd_out = disp[idx].
  - SHOW for the remainder of the slot: an[idx] = 0, all other anode bits 1.
  - BLANK -> SHOW when cnt == BLANK_CYCLES-1.
  - SHOW -> BLANK on slot wrap.
- Output timing: registered outputs reflect state one cycle after the cnt/idx values that produced them. an and bcd_out change only on those cycles.
- Load handshake:
  - load high for a cycle captures digits_in into the pending buffer and sets pending.
  - A further load before commit overwrites the pending buffer; latest wins, with no extra ack.
  - Commit happens only at the frame boundary, i.e. the cycle with cnt == PRESCALE-1 and idx == NUM_DIGITS-1. At commit, disp <= pending buffer, pending is cleared, and load_ack pulses in the next cycle.
  - Load in the boundary cycle itself: digits_in bypasses directly into disp, load_ack pulses, and pending is cleared.
  - frame_tick pulses in the same cycle as any boundary-commit load_ack.
- Digit codes 10..15 pass through unchanged; decoding them is the decoder's concern.
- The load level is not a busy signal; the producer may assert load in any cycle.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, any digit k > 0 whose value is 0 and all of whose more-significant digits are 0 keeps an high. Digit 0 is always shown. The mask is computed from disp at commit time and registered with it.
- Undefined: every digit is shown during SHOW.

Decomposition:
- Shared package seg7_pkg:
  - FSM state encoding: BLANK = 1'b0, SHOW = 1'b1.
  - Localparam helper for the cnt width, $clog2(PRESCALE).
  - Default timing constants.
- One natural sub-module, seg7_digit_buffer, owns:
  - pending/disp registers;
  - the pending flag;
  - commit, bypass and ack logic;
  - the optional leading-zero mask.
- The scan FSM and counters stay in the top module.

Test Plan:
All scenarios use PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=4.
- Reset, then 40 cycles -> an cycles 1111 (2 cycles), 1110 (6), 1111 (2), 1101 (6) ...; bcd_out=0 throughout; frame_tick every 32 cycles.
- load=1 for one cycle with digits_in=16'h4321 at cycle 5 -> no change until the frame boundary; load_ack pulses once at cycle 32; next frame shows bcd_out 1,2,3,4 with an 1110, 1101, 1011, 0111.
- Loads of 16'h1111 then 16'h2222 in the same frame -> exactly one load_ack; next frame displays 2,2,2,2.
- Load 16'h9876 in the boundary cycle (cnt=7, idx=3) -> load_ack in the next cycle; the immediately following frame shows 6,7,8,9.
- Assert rst for one cycle mid-SHOW of digit 2 with a pending load -> next cycle an=1111, idx=0, cnt=0; no load_ack; disp is 0.
- With SEG7_LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> digit 3 anode never low; digits 1 and 0 show 5 and 0; digit 2 anode never low.
